// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default constants for the RX and TX paths
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for an idle-high asynchronous input
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the raw input through the chain; reset to the line's idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with holding register; optional parity via UART_RX_PARITY_EN
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_d;
  logic [TW-1:0]        tick_cnt, tick_d;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 rxs;
  logic                 frame_done;
  logic                 par_ok;
  logic                 good;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_d;

  // received parity bit register
  always_ff @(posedge clk) begin
    if (rst) par_bit <= 1'b0;
    else     par_bit <= par_d;
  end

  // even parity: data bits plus the parity bit must XOR to zero
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok = 1'b1;
`endif

  // next-state logic: every decision is taken on a baud_tick using the synced line
  always_comb begin
    state_d    = state;
    tick_d     = tick_cnt;
    bit_d      = bit_cnt;
    shreg_d    = shreg;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_bit;
`endif
    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            if (!rxs) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = BIT_LAST;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shreg_d = {rxs, shreg[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_cnt == '0) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_cnt - 1'b1;
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick_cnt == TICK_LAST) begin
            par_d   = rxs;
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
`else
          state_d = IDLE;
`endif
        end
        STOP: begin
          // return to IDLE at mid stop bit so a back-to-back start edge is caught
          if (tick_cnt == TICK_LAST) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, counter and shift register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
    end
  end

  assign good = frame_done && rxs && par_ok;

  // holding register: a same-cycle accept frees the slot for the new byte
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_done && !rxs;
      overrun_err <= 1'b0;
      if (good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity error pulses alongside frame_err when both are bad
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= frame_done && !par_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BIT_CLKS = 64;
  localparam int DONE_OFF = 36 + BIT_CLKS * (8 + 1 + PB);

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  int passed = 0;
  int total  = 0;

  int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vcyc_cnt = 0, vrise_cnt = 0;
  logic valid_q = 1'b0;
  int   fe0, ov0, pe0, vcyc0, vrise0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  // baud_tick high for one clock out of every four
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #2 baud_tick = 1'b1;
      @(posedge clk);
      #2 baud_tick = 1'b0;
    end
  end

  // event counters on DUT outputs, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_err)   fe_cnt    <= fe_cnt + 1;
    if (overrun_err) ov_cnt    <= ov_cnt + 1;
    if (parity_err)  pe_cnt    <= pe_cnt + 1;
    if (rx_valid)    vcyc_cnt  <= vcyc_cnt + 1;
    if (rx_valid && !valid_q) vrise_cnt <= vrise_cnt + 1;
    valid_q <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; vcyc0 = vcyc_cnt; vrise0 = vrise_cnt;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input bit ready_pulse);
    while (baud_tick !== 1'b1) @(negedge clk);
    fork
      begin
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
          rx = d[i];
          wait_clks(BIT_CLKS);
        end
        if (PB == 1) begin
          rx = par_b;
          wait_clks(BIT_CLKS);
        end
        rx = stop_b;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
      end
      begin
        if (ready_pulse) begin
          wait_clks(DONE_OFF);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
    join
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    wait_clks(3);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun_err", 32'(overrun_err), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    wait_clks(8);

    // clean frame with consumer ready
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_valid_cycles", 32'(vcyc_cnt - vcyc0), 32'd1);
    check("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("t1_overrun", 32'(ov_cnt - ov0), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_valid_end", 32'(rx_valid), 32'd0);

    // start-bit glitch
    snap();
    while (baud_tick !== 1'b1) @(negedge clk);
    rx = 1'b0;
    wait_clks(10);
    check("t2_busy_in_start", 32'(busy), 32'd1);
    wait_clks(6);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("t2_no_valid", 32'(vrise_cnt - vrise0), 32'd0);
    check("t2_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("t2_busy_idle", 32'(busy), 32'd0);

    // bad stop bit, then a good frame
    snap();
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    wait_clks(2 * BIT_CLKS);
    check("t3_frame_err_once", 32'(fe_cnt - fe0), 32'd1);
    check("t3_no_valid", 32'(vrise_cnt - vrise0), 32'd0);
    check("t3_valid_low", 32'(rx_valid), 32'd0);
    snap();
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0);
    check("t3_next_data", 32'(rx_data), 32'h55);
    check("t3_next_valid", 32'(vrise_cnt - vrise0), 32'd1);
    check("t3_next_no_err", 32'(fe_cnt - fe0), 32'd0);

    // back-to-back with consumer stalled: overrun
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
    check("t4_data_kept", 32'(rx_data), 32'h11);
    check("t4_valid", 32'(rx_valid), 32'd1);
    check("t4_overrun_once", 32'(ov_cnt - ov0), 32'd1);
    check("t4_one_load", 32'(vrise_cnt - vrise0), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("t4_accept_clears", 32'(rx_valid), 32'd0);
    check("t4_data_after_accept", 32'(rx_data), 32'h11);

    // accept in the completion cycle: new byte loads, no overrun
    snap();
    send_frame(8'h33, 1'b1, ^8'h33, 1'b0);
    check("t5_first_data", 32'(rx_data), 32'h33);
    check("t5_first_valid", 32'(rx_valid), 32'd1);
    send_frame(8'h22, 1'b1, ^8'h22, 1'b1);
    check("t5_data_replaced", 32'(rx_data), 32'h22);
    check("t5_valid_stays", 32'(rx_valid), 32'd1);
    check("t5_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    check("t5_valid_never_fell", 32'(vrise_cnt - vrise0), 32'd1);

    // reset in the middle of a frame's data bits
    fork
      send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0);
      begin
        wait_clks(200);
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        check("t5_rst_valid", 32'(rx_valid), 32'd0);
        check("t5_rst_data", 32'(rx_data), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'd0);
        snap();
      end
    join
    wait_clks(BIT_CLKS);
    check("t5_post_rst_no_valid", 32'(vrise_cnt - vrise0), 32'd0);
    check("t5_post_rst_no_err", 32'(fe_cnt - fe0), 32'd0);
    check("t5_post_rst_busy", 32'(busy), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs parity bit 1
    rx_ready = 1'b1;
    snap();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("t6_parity_err_once", 32'(pe_cnt - pe0), 32'd1);
    check("t6_bad_no_valid", 32'(vrise_cnt - vrise0), 32'd0);
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("t6_good_data", 32'(rx_data), 32'h07);
    check("t6_good_valid", 32'(vrise_cnt - vrise0), 32'd1);
    check("t6_good_no_perr", 32'(pe_cnt - pe0), 32'd0);
`else
    check("no_parity_err_ever", 32'(pe_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
